pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised successor to the single-cycle program counter: holds the fetch PC and selects the next PC each enabled edge.
- Next-PC sources: reset vector, trap vector, saved exception PC (mret), branch/jump target, return-address stack (RAS) prediction, sequential increment.
- Sits at the head of the fetch path; drives instruction-memory address and pc_plus_4 to the datapath.
- Adds stall, alignment trapping, a trap/return FSM and a circular RAS.

Parameters:
- XLEN, 32, PC and target width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- RAS_DEPTH, 4, RAS entries; power of two, minimum 2.

Ports:
- clk, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous, active-high.
- clk_enable, in, 1, qualifies every state update; low means all state holds.
- stall, in, 1, hold PC. Lower priority than trap, mret and pc_src.
- pc_src, in, 1, take pc_target this cycle.
- pc_target, in, XLEN, redirect address.
- call, in, 1, with an accepted pc_src: push pc_plus_4 onto the RAS.
- ret, in, 1, redirect to RAS top and pop.
- trap, in, 1, external exception request.
- mret, in, 1, return from trap to epc.
- pc, out, XLEN, current fetch PC.
- pc_plus_4, out, XLEN, combinational pc + 4, wraps modulo 2^XLEN.
- epc, out, XLEN, saved exception PC.
- in_trap, out, 1, FSM is in state TRAP.
- misaligned, out, 1, registered one-cycle pulse when a redirect was rejected.
- ras_empty, out, 1, RAS count == 0.
- ras_full, out, 1, RAS count == RAS_DEPTH.

Behaviour:
- Reset (asynchronous) takes effect immediately and overrides everything:
  - pc = RESET_VECTOR, epc = 0, FSM = RUN, in_trap = 0, misaligned = 0.
  - RAS count = 0, pointer = 0, so ras_empty = 1 and ras_full = 0.
- Updates happen only on a rising clk edge with clk_enable = 1. With clk_enable = 0, all registers hold and misaligned holds its value.
- Next-PC priority, highest first:
  - trap: pc = TRAP_VECTOR. In RUN, epc = pc and FSM goes RUN -> TRAP. In TRAP, epc is unchanged (nested trap does not clobber it).
  - mret while in TRAP: pc = epc, FSM goes TRAP -> RUN. mret in RUN is ignored and falls through to lower priorities.
  - pc_src with pc_target[1:0] != 0: no redirect. pc = TRAP_VECTOR, misaligned = 1 for one enabled cycle, and epc/FSM update exactly as for trap. No call push.
  - pc_src, aligned: pc = pc_target. If call = 1, push pc_plus_4.
  - ret with RAS not empty: pc = RAS top, then pop. ret with RAS empty: treated as sequential, no pop.
  - stall: pc holds.
  - otherwise: pc = pc_plus_4.
- RAS rules:
  - Circular buffer of RAS_DEPTH entries.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - ret is evaluated only when pc_src = 0, so call and ret never act in the same cycle.
  - trap, mret and misaligned cycles leave the RAS untouched.
- misaligned deasserts on the next enabled edge that does not reject a redirect.
- Arithmetic is unsigned modulo 2^XLEN. pc_plus_4 from 32'hFFFF_FFFC is 32'h0000_0000.
- No output is X after reset.

Test Plan:
- Reset held for 100 ns, then released for 3 cycles -> pc 0x0 then 0xC; pc_plus_4 0x10; ras_empty = 1.
- pc_src = 1, call = 1, pc_target = 0x170 at pc = 0xC -> pc 0x170, ras_empty = 0. Two cycles later ret = 1 -> pc 0x10, ras_empty = 1.
- pc_src = 1, pc_target = 0x172 at pc = 0x20 -> pc 0x100, misaligned = 1 for one cycle, epc 0x20, in_trap = 1. Then mret -> pc 0x20, in_trap = 0.
- Five calls with RAS_DEPTH = 4 to targets 0x400, 0x500, 0x600, 0x700, 0x800 -> ras_full = 1; four rets return the newest four pc_plus_4 values; a fifth ret -> sequential increment.
- Second trap while in TRAP -> pc 0x100, epc unchanged. stall + pc_src -> pc = target. clk_enable = 0 for 3 cycles -> pc unchanged.
- Reset asserted mid-cycle while pc = 0x300 and in_trap = 1 -> pc 0x0, in_trap 0, epc 0, ras_empty 1, with no clock edge needed.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with prioritised next-PC selection,
// a RUN/TRAP return FSM and a circular return-address stack.
`default_nettype none

module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_enable,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic [XLEN-1:0] epc,
  output logic            in_trap,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_ptr;   // next slot to write; top of stack is ras_ptr-1
  logic [CW-1:0]   ras_count;
  logic [PW-1:0]   ras_top_idx;
  logic            target_bad;

  assign pc_plus_4   = pc + XLEN'(4);
  assign in_trap     = (state == TRAP);
  assign ras_empty   = (ras_count == '0);
  assign ras_full    = (ras_count == FULL_COUNT);
  assign ras_top_idx = ras_ptr - PW'(1);
  assign target_bad  = (pc_target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      state      <= RUN;
      misaligned <= 1'b0;
      ras_ptr    <= '0;
      ras_count  <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (clk_enable) begin
      misaligned <= 1'b0;
      if (trap || (pc_src && target_bad && !(mret && state == TRAP))) begin
        // A rejected redirect enters the trap exactly like an external trap.
        pc         <= TRAP_VECTOR;
        misaligned <= !trap;
        if (state == RUN) begin
          epc   <= pc;
          state <= TRAP;
        end
      end else if (mret && state == TRAP) begin
        pc    <= epc;
        state <= RUN;
      end else if (pc_src) begin
        pc <= pc_target;
        if (call) begin
          // When full, the write slot wraps onto the oldest entry.
          ras_mem[ras_ptr] <= pc_plus_4;
          ras_ptr          <= ras_ptr + PW'(1);
          if (ras_count != FULL_COUNT) ras_count <= ras_count + CW'(1);
        end
      end else if (ret && !ras_empty) begin
        pc        <= ras_mem[ras_top_idx];
        ras_ptr   <= ras_top_idx;
        ras_count <= ras_count - CW'(1);
      end else if (!stall) begin
        pc <= pc_plus_4;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plan plus randomized stimulus for pc_gen, checked
// against a queue-based behavioural model.
`default_nettype none

module tb_pc_gen;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0, stall = 1'b0, pc_src = 1'b0;
  logic [31:0] pc_target = '0;
  logic        call = 1'b0, ret = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [31:0] pc, pc_plus_4, epc;
  logic        in_trap, misaligned, ras_empty, ras_full;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_trap, m_mis;
  logic [31:0] m_ras[$];

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .stall(stall),
    .pc_src(pc_src), .pc_target(pc_target), .call(call), .ret(ret),
    .trap(trap), .mret(mret), .pc(pc), .pc_plus_4(pc_plus_4), .epc(epc),
    .in_trap(in_trap), .misaligned(misaligned), .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RV; m_epc = '0; m_trap = 1'b0; m_mis = 1'b0;
    m_ras.delete();
  endtask

  task automatic enter_trap();
    if (!m_trap) begin
      m_epc  = m_pc;
      m_trap = 1'b1;
    end
    m_pc = TV;
  endtask

  // One enabled-or-not edge as described by the priority list.
  task automatic model_edge();
    if (!clk_enable) return;
    m_mis = 1'b0;
    if (trap) enter_trap();
    else if (mret && m_trap) begin
      m_pc = m_epc; m_trap = 1'b0;
    end else if (pc_src && pc_target[1:0] != 2'b00) begin
      enter_trap();
      m_mis = 1'b1;
    end else if (pc_src) begin
      if (call) begin
        if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
        m_ras.push_back(m_pc + 32'd4);
      end
      m_pc = pc_target;
    end else if (ret && m_ras.size() != 0) m_pc = m_ras.pop_back();
    else if (!stall) m_pc = m_pc + 32'd4;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc,                  m_pc);
    check({tag, ".pc4"},   pc_plus_4,           m_pc + 32'd4);
    check({tag, ".epc"},   epc,                 m_epc);
    check({tag, ".trap"},  {31'd0, in_trap},    {31'd0, m_trap});
    check({tag, ".mis"},   {31'd0, misaligned}, {31'd0, m_mis});
    check({tag, ".empty"}, {31'd0, ras_empty},  {31'd0, m_ras.size() == 0});
    check({tag, ".full"},  {31'd0, ras_full},   {31'd0, m_ras.size() == DEPTH});
  endtask

  task automatic step(input string tag, input logic en, input logic st, input logic src,
                      input logic [31:0] tgt, input logic cl, input logic rt,
                      input logic tr, input logic mr);
    @(negedge clk);
    clk_enable = en; stall = st; pc_src = src; pc_target = tgt;
    call = cl; ret = rt; trap = tr; mret = mr;
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1, 0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #50 check_all("reset");
    #50 reset = 1'b0;

    seq("run0"); seq("run1"); seq("run2");
    check("plan_pc_c", pc, 32'h0000_000C);
    check("plan_pc4_10", pc_plus_4, 32'h0000_0010);

    step("call170", 1, 0, 1, 32'h170, 1, 0, 0, 0);
    check("plan_call_pc", pc, 32'h170);
    seq("c1"); seq("c2");
    step("ret10", 1, 0, 0, '0, 0, 1, 0, 0);
    check("plan_ret_pc", pc, 32'h10);
    check("plan_ret_empty", {31'd0, ras_empty}, 32'd1);

    seq("s14"); seq("s18"); seq("s1c"); seq("s20");
    step("mis", 1, 0, 1, 32'h172, 0, 0, 0, 0);
    check("plan_mis_pc", pc, 32'h100);
    check("plan_mis_epc", epc, 32'h20);
    check("plan_mis_flag", {31'd0, misaligned}, 32'd1);
    step("mret", 1, 0, 0, '0, 0, 0, 0, 1);
    check("plan_mret_pc", pc, 32'h20);
    check("plan_mis_clear", {31'd0, misaligned}, 32'd0);

    for (int i = 0; i < 5; i++)
      step("call5", 1, 0, 1, 32'h400 + 32'h100 * i, 1, 0, 0, 0);
    check("plan_full", {31'd0, ras_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("ret4", 1, 0, 0, '0, 0, 1, 0, 0);
      check("plan_ret_order", pc, 32'h704 - 32'h100 * i);
    end
    step("ret_empty", 1, 0, 0, '0, 0, 1, 0, 0);
    check("plan_ret_seq", pc, 32'h408);

    step("trap1", 1, 0, 0, '0, 0, 0, 1, 0);
    seq("t1");
    step("trap2", 1, 0, 0, '0, 0, 0, 1, 0);
    check("plan_nested_pc", pc, 32'h100);
    check("plan_nested_epc", epc, 32'h408);
    step("stall_src", 1, 1, 1, 32'h300, 0, 0, 0, 0);
    check("plan_stall_src", pc, 32'h300);
    for (int i = 0; i < 3; i++) step("gated", 0, 0, 1, 32'h800, 1, 0, 1, 0);
    check("plan_gated_pc", pc, 32'h300);

    // Asynchronous reset in the middle of the low phase.
    @(negedge clk); #2;
    reset = 1'b1; #1;
    model_reset();
    check("async_pc", pc, 32'h0);
    check("async_trap", {31'd0, in_trap}, 32'd0);
    check("async_epc", epc, 32'h0);
    check("async_empty", {31'd0, ras_empty}, 32'd1);
    check_all("async");
    @(negedge clk); reset = 1'b0;

    // Wrap of pc_plus_4 at the top of the address space.
    step("to_top", 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    check("wrap_pc4", pc_plus_4, 32'h0);
    seq("wrap");

    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      step("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, t, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
